// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, multi-cycle memory between the
// instruction-fetch (IF) and data-memory (MEM) pipeline stages. One requester
// is granted at a time. The granted request is latched into the memory-side
// registers. Completion is returned as a one-cycle ready pulse with the read data.
// MEM normally wins arbitration. After MAX_DM_BURST consecutive MEM grants made
// while IF was waiting, IF is granted once so it is never starved.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DM_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int               CNT_W     = 4;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DM_BURST);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic               if_ready_q, if_ready_d;
  logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
  logic               dm_ready_q, dm_ready_d;

  // Arbitration, request latching and completion handling for the next cycle
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!if_req) begin
          burst_cnt_d = '0;
        end
        if (dm_req && !(if_req && (burst_cnt_q == BURST_MAX))) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end else if (if_req) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          burst_cnt_d = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          state_d    = DONE;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
          dm_ready_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;

  // Stalls are combinational so the pipeline freezes in the same cycle as the request
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by a randomized run.
// The randomized run is checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MAX_DM_BURST = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              stall_if;
  logic              stall_mem;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_DM_BURST(MAX_DM_BURST)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_if (stall_if),
    .stall_mem(stall_mem)
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if ({mem_req, mem_we, if_ready, dm_ready} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_ctrl: got %b, want 0000", {mem_req, mem_we, if_ready, dm_ready}); end
    tests_run++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'd0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h, want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata}); end
    @(negedge clock);
    reset = 1'b1;
    tick();
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_idle: got %b, want 0", mem_req); end
  endtask

  task automatic test_fetch_zero_wait();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1;
    tests_run++; if (stall_if !== 1'b1) begin tests_failed++; $display("[TB] FAIL fetch_stall_c0: got %b, want 1", stall_if); end
    tick();
    tests_run++; if ({mem_req, mem_we} !== 2'b10) begin tests_failed++; $display("[TB] FAIL fetch_mem_req_c1: got %b, want 10", {mem_req, mem_we}); end
    tests_run++; if (mem_addr !== 32'h0000_0040) begin tests_failed++; $display("[TB] FAIL fetch_addr: got %h, want 00000040", mem_addr); end
    tests_run++; if (stall_if !== 1'b1) begin tests_failed++; $display("[TB] FAIL fetch_stall_c1: got %b, want 1", stall_if); end
    mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tests_run++; if ({if_ready, mem_req, stall_if} !== 3'b100) begin tests_failed++; $display("[TB] FAIL fetch_ready_c2: got %b, want 100", {if_ready, mem_req, stall_if}); end
    tests_run++; if (if_rdata !== 32'h8C01_0004) begin tests_failed++; $display("[TB] FAIL fetch_rdata: got %h, want 8c010004", if_rdata); end
    if_req = 1'b0;
    tick();
    tests_run++; if ({if_ready, if_rdata} !== {1'b0, 32'h8C01_0004}) begin tests_failed++; $display("[TB] FAIL fetch_hold: got %b/%h, want 0/8c010004", if_ready, if_rdata); end
    tick();
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h0000_0100;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0010; dm_wdata = 32'hDEAD_BEEF;
    tick();
    tests_run++; if ({mem_req, mem_we} !== 2'b11) begin tests_failed++; $display("[TB] FAIL prio_dm_grant: got %b, want 11", {mem_req, mem_we}); end
    tests_run++; if ({mem_addr, mem_wdata} !== {32'h10, 32'hDEAD_BEEF}) begin tests_failed++; $display("[TB] FAIL prio_dm_latch: got %h/%h, want 00000010/deadbeef", mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests_run++; if ({dm_ready, if_ready} !== 2'b10) begin tests_failed++; $display("[TB] FAIL prio_dm_ready: got %b, want 10", {dm_ready, if_ready}); end
    dm_req = 1'b0;
    tick();
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL prio_done_no_grant: got %b, want 0", mem_req); end
    tick();
    tests_run++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin tests_failed++; $display("[TB] FAIL prio_if_grant: got %b%b/%h, want 10/00000100", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
    tick();
    mem_ack = 1'b0;
    tests_run++; if ({if_ready, if_rdata} !== {1'b1, 32'h1111}) begin tests_failed++; $display("[TB] FAIL prio_if_ready: got %b/%h, want 1/00001111", if_ready, if_rdata); end
    if_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_burst_limit();
    logic [ADDR_W-1:0] want_order [6];
    int waitc;
    want_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200, 32'h300};
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int g = 0; g < 6; g++) begin
      waitc = 0;
      while (mem_req !== 1'b1 && waitc < 20) begin
        tick();
        waitc++;
      end
      tests_run++; if (mem_req !== 1'b1 || mem_addr !== want_order[g]) begin tests_failed++; $display("[TB] FAIL burst_grant_%0d: got req=%b addr=%h, want req=1 addr=%h", g, mem_req, mem_addr, want_order[g]); end
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0;
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_wait_states();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0020;
    tick();
    for (int c = 0; c < 4; c++) begin
      tests_run++; if ({mem_req, dm_ready, mem_addr} !== {2'b10, 32'h20}) begin tests_failed++; $display("[TB] FAIL wait_hold_%0d: got %b%b/%h, want 10/00000020", c, mem_req, dm_ready, mem_addr); end
      if (c == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tests_run++; if ({dm_ready, mem_req, dm_rdata} !== {2'b10, 32'hCAFE_F00D}) begin tests_failed++; $display("[TB] FAIL wait_ready: got %b%b/%h, want 10/cafef00d", dm_ready, mem_req, dm_rdata); end
    dm_req = 1'b0;
    tick();
    tests_run++; if ({dm_ready, dm_rdata} !== {1'b0, 32'hCAFE_F00D}) begin tests_failed++; $display("[TB] FAIL wait_single_pulse: got %b/%h, want 0/cafef00d", dm_ready, dm_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0044;
    tick();
    tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_busy: got %b, want 1", mem_req); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if ({mem_req, dm_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_async: got %b, want 00", {mem_req, dm_ready}); end
    tick();
    tests_run++; if ({mem_req, dm_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_held: got %b, want 00", {mem_req, dm_ready}); end
    @(negedge clock);
    reset = 1'b1;
    tick();
    tests_run++; if ({mem_req, dm_ready, mem_addr} !== {2'b10, 32'h44}) begin tests_failed++; $display("[TB] FAIL rst_regrant: got %b%b/%h, want 10/00000044", mem_req, dm_ready, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    tests_run++; if ({dm_ready, dm_rdata} !== {1'b1, 32'h1234_5678}) begin tests_failed++; $display("[TB] FAIL rst_complete: got %b/%h, want 1/12345678", dm_ready, dm_rdata); end
    dm_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_spurious_ack();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    tests_run++; if ({if_ready, dm_ready, mem_req} !== 3'b000) begin tests_failed++; $display("[TB] FAIL spur_no_pulse: got %b, want 000", {if_ready, dm_ready, mem_req}); end
    tests_run++; if ({if_rdata, dm_rdata} !== {32'h0, 32'h1234_5678}) begin tests_failed++; $display("[TB] FAIL spur_rdata: got %h/%h, want 00000000/12345678", if_rdata, dm_rdata); end
    if_req = 1'b1; if_addr = 32'h0000_0080;
    tick();
    tests_run++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin tests_failed++; $display("[TB] FAIL spur_still_idle: got %b/%h, want 1/00000080", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    tests_run++; if ({if_ready, if_rdata} !== {1'b1, 32'h0BAD_F00D}) begin tests_failed++; $display("[TB] FAIL spur_after_fetch: got %b/%h, want 1/0badf00d", if_ready, if_rdata); end
    if_req = 1'b0;
    tick(); tick();
  endtask

  // Randomized traffic against a transaction-level model of the arbiter
  task automatic test_random();
    int               owner;
    bit               cooling;
    int               streak;
    int               wait_left;
    logic             m_mem_req, m_we, m_if_ready, m_dm_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_if_rdata, m_dm_rdata;
    logic             p_if_req, p_dm_req, p_dm_we, p_ack;
    logic [ADDR_W-1:0] p_if_addr, p_dm_addr;
    logic [DATA_W-1:0] p_dm_wdata, p_rdata;

    reset = 1'b0;
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    owner = 0; cooling = 1'b0; streak = 0; wait_left = 0;
    m_mem_req = 1'b0; m_we = 1'b0; m_if_ready = 1'b0; m_dm_ready = 1'b0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      p_if_req = if_req; p_if_addr = if_addr;
      p_dm_req = dm_req; p_dm_we = dm_we; p_dm_addr = dm_addr; p_dm_wdata = dm_wdata;
      p_ack = mem_ack; p_rdata = mem_rdata;
      tick();

      m_if_ready = 1'b0;
      m_dm_ready = 1'b0;
      if (owner != 0) begin
        if (p_ack) begin
          if (owner == 1) begin
            m_if_ready = 1'b1;
            m_if_rdata = p_rdata;
          end else begin
            m_dm_ready = 1'b1;
            if (!m_we) m_dm_rdata = p_rdata;
          end
          owner = 0;
          m_mem_req = 1'b0;
          cooling = 1'b1;
        end
      end else if (cooling) begin
        cooling = 1'b0;
      end else begin
        if (p_dm_req && !(p_if_req && streak == MAX_DM_BURST)) begin
          owner = 2; m_we = p_dm_we; m_addr = p_dm_addr; m_wdata = p_dm_wdata;
          streak = p_if_req ? streak + 1 : 0;
        end else if (p_if_req) begin
          owner = 1; m_we = 1'b0; m_addr = p_if_addr; m_wdata = '0;
          streak = 0;
        end else begin
          streak = 0;
        end
        if (owner != 0) begin
          m_mem_req = 1'b1;
          wait_left = $urandom_range(0, 3);
        end
      end

      tests_run++; if ({mem_req, if_ready, dm_ready} !== {m_mem_req, m_if_ready, m_dm_ready}) begin tests_failed++; $display("[TB] FAIL rand_handshake cyc %0d: got %b, want %b", cyc, {mem_req, if_ready, dm_ready}, {m_mem_req, m_if_ready, m_dm_ready}); end
      tests_run++; if ({if_rdata, dm_rdata} !== {m_if_rdata, m_dm_rdata}) begin tests_failed++; $display("[TB] FAIL rand_rdata cyc %0d: got %h/%h, want %h/%h", cyc, if_rdata, dm_rdata, m_if_rdata, m_dm_rdata); end
      if (m_mem_req) begin
        tests_run++; if ({mem_we, mem_addr, mem_wdata} !== {m_we, m_addr, m_wdata}) begin tests_failed++; $display("[TB] FAIL rand_latch cyc %0d: got %b/%h/%h, want %b/%h/%h", cyc, mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata); end
      end

      if (if_req) begin
        if (m_if_ready) begin
          if ($urandom_range(0, 1) == 0) if_req = 1'b0;
          else if_addr = $urandom;
        end else if ($urandom_range(0, 63) == 0) begin
          if_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end

      if (dm_req) begin
        if (m_dm_ready) begin
          if ($urandom_range(0, 3) == 0) dm_req = 1'b0;
          else begin
            dm_addr = $urandom; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          dm_req = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        dm_req = 1'b1; dm_addr = $urandom; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
      end

      mem_rdata = $urandom;
      if (m_mem_req) begin
        if (wait_left == 0) mem_ack = 1'b1;
        else begin
          mem_ack = 1'b0;
          wait_left--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
      end

      #1;
      tests_run++; if ({stall_if, stall_mem} !== {if_req & ~m_if_ready, dm_req & ~m_dm_ready}) begin tests_failed++; $display("[TB] FAIL rand_stall cyc %0d: got %b, want %b", cyc, {stall_if, stall_mem}, {if_req & ~m_if_ready, dm_req & ~m_dm_ready}); end
    end

    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    tick(); tick(); tick();
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_priority();
    test_burst_limit();
    test_wait_states();
    test_reset_mid_access();
    test_spurious_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
